div_unit: RTL

- Iterative radix-2 divider serving DIV/DIVU for the EX stage.
- EX initiates an operation with a start pulse and stalls while busy. The divider responds with done plus quotient and remainder, which EX writes to LO and HI respectively.
- Supports signed and unsigned operation, cancellation on pipeline flush, and defined divide-by-zero results.

---
 rtl/div_if.sv | 30 +++
 rtl/div_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/div_if.sv
// Request/response bundle between the EX stage (master) and the iterative divider (slave).
// start/cancel are level requests; done is held until ack or cancel clears it.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ack;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Handshake: start is taken only while busy=0 and cancel=0, so EX holds it
  // until busy rises. done stays high with stable results until ack or cancel
  // is seen in DONE; a start in that same cycle is dropped and must be reissued.
  modport master (
    output start, signed_op, dividend, divisor, ack, cancel,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor, ack, cancel,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on operand
// magnitudes, with a sign fix-up applied as the last iteration retires.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  div_if.slave       bus,
  output logic [1:0] o_state
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             r_signed;
  logic             r_dvd_neg;
  logic             r_dvs_neg;
  logic [WIDTH-1:0] r_dvs_mag;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_prem;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH:0]   w_prem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_accept   = (r_state == S_IDLE) && bus.start && !bus.cancel;
  assign w_div_zero = (bus.divisor == '0);
  assign w_dvd_neg  = bus.signed_op && bus.dividend[WIDTH-1];
  assign w_dvs_neg  = bus.signed_op && bus.divisor[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? -bus.dividend : bus.dividend;
  assign w_dvs_mag  = w_dvs_neg ? -bus.divisor  : bus.divisor;

  // r_q starts as the dividend magnitude; its MSB feeds the partial remainder
  // while quotient bits fill in from the LSB, so after WIDTH steps it holds the quotient.
  assign w_shift    = {r_prem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs_mag};
  assign w_qbit     = !w_diff[WIDTH];
  assign w_prem_nxt = w_qbit ? w_diff : w_shift;
  assign w_q_nxt    = {r_q[WIDTH-2:0], w_qbit};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_quot_fix = (r_signed && (r_dvd_neg != r_dvs_neg)) ? -w_q_nxt : w_q_nxt;
  assign w_rem_fix  = (r_signed && r_dvd_neg) ? -w_prem_nxt[WIDTH-1:0]
                                              : w_prem_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_div_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (bus.cancel) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.ack || bus.cancel) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (r_state != S_IDLE);
    bus.done        = (r_state == S_DONE);
    bus.div_by_zero = r_dbz && (r_state == S_DONE);
    bus.quotient    = r_quot;
    bus.remainder   = r_rem;
    o_state         = r_state;
  end

  // Result registers change only on an accepted divide-by-zero start or on the
  // final iteration, so a cancelled operation leaves the previous result intact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_signed  <= 1'b0;
      r_dvd_neg <= 1'b0;
      r_dvs_neg <= 1'b0;
      r_dvs_mag <= '0;
      r_q       <= '0;
      r_prem    <= '0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz     <= 1'b0;
    end else if (w_accept) begin
      r_signed  <= bus.signed_op;
      r_dvd_neg <= w_dvd_neg;
      r_dvs_neg <= w_dvs_neg;
      r_dvs_mag <= w_dvs_mag;
      r_q       <= w_dvd_mag;
      r_prem    <= '0;
      r_cnt     <= '0;
      r_dbz     <= w_div_zero;
      if (w_div_zero) begin
        r_quot <= '1;
        r_rem  <= bus.dividend;
      end
    end else if ((r_state == S_CALC) && !bus.cancel) begin
      r_prem <= w_prem_nxt;
      r_q    <= w_q_nxt;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_quot <= w_quot_fix;
        r_rem  <= w_rem_fix;
      end
    end
  end
endmodule
